// File: rtl/seg_pkg.sv
// Shared types, glyph table and sizing helpers for the seven-segment scan display.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic { MODE_HEX = 1'b0, MODE_DEC = 1'b1 } disp_mode_e;
  typedef enum logic { ST_IDLE = 1'b0, ST_CONV = 1'b1 } disp_state_e;

  // ceil(width * log10(2)) decimal digits are enough for any width-bit value
  function automatic int bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, DATA_W cycles per conversion.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BCD_N  = bcd_digits(DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*BCD_N-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0]  sr;
  logic [4*BCD_N-1:0] bcd_r, adj, bcd_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               shift_out_unused;

  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < BCD_N; i++)
      if (bcd_r[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
  end

  assign {shift_out_unused, bcd_nxt} = {adj, sr[DATA_W-1]};

  // done flags the cycle whose shift completes the result; bcd carries that
  // post-shift value so the consumer can commit on the same edge busy drops
  assign done = busy && (cnt == CNT_W'(DATA_W-1));
  assign bcd  = bcd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      sr    <= '0;
      bcd_r <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      cnt   <= '0;
      sr    <= bin;
      bcd_r <= '0;
    end else if (busy) begin
      bcd_r <= bcd_nxt;
      sr    <= {sr[DATA_W-2:0], 1'b0};
      cnt   <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment controller: hex or decimal display of a loaded value.
// Optional leading-zero blanking when SEG_LZB_EN is defined.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 23000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  input  logic              mode,
  output logic              busy,
  output logic [6:0]        seg_out,
  output logic [DIGITS-1:0] digit_select
);

  localparam int BCD_N  = bcd_digits(DATA_W);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RCNT_W = $clog2(REFRESH_DIV);
  localparam int HEX_W  = (DATA_W > 4*DIGITS) ? DATA_W : 4*DIGITS;
  localparam int DEC_W  = (BCD_N > DIGITS) ? 4*BCD_N : 4*DIGITS;

`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  disp_state_e state, state_nxt;
  logic conv_start, conv_busy, conv_done;
  logic [4*BCD_N-1:0] conv_bcd;
  logic hex_wr;

  logic [DIGITS-1:0][3:0] disp_buf, hex_nib, dec_nib;
  logic                   disp_ovf, dec_ovf;
  logic [HEX_W-1:0]       hex_ext;
  logic [DEC_W-1:0]       dec_ext;

  logic [RCNT_W-1:0] refresh_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic [DIGITS-1:0] blank;
  logic [6:0]        glyph_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    hex_wr     = 1'b0;
    case (state)
      ST_IDLE: if (load) begin
        if (disp_mode_e'(mode) == MODE_DEC) begin
          conv_start = 1'b1;
          state_nxt  = ST_CONV;
        end else begin
          hex_wr = 1'b1;
        end
      end
      ST_CONV: if (conv_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_N(BCD_N)) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign busy = conv_busy;

  // Zero-extend both sources so digits past the source width read as 0
  assign hex_ext = HEX_W'(value);
  assign dec_ext = DEC_W'(conv_bcd);

  always_comb begin
    dec_ovf = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      hex_nib[i] = hex_ext[4*i +: 4];
      dec_nib[i] = dec_ext[4*i +: 4];
    end
    for (int k = DIGITS; k < BCD_N; k++)
      if (dec_ext[4*k +: 4] != 4'd0) dec_ovf = 1'b1;
  end

  // Buffer only ever changes as a whole, so a conversion commit is atomic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_buf <= '0;
      disp_ovf <= 1'b0;
    end else if (hex_wr) begin
      disp_buf <= hex_nib;
      disp_ovf <= 1'b0;
    end else if (conv_done) begin
      disp_buf <= dec_nib;
      disp_ovf <= dec_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == RCNT_W'(REFRESH_DIV-1)) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == IDX_W'(DIGITS-1)) ? '0 : scan_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Walk down from the top digit; blank while everything above is zero
  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      zero_run = zero_run && (disp_buf[i] == 4'd0);
      blank[i] = LZB && zero_run;
    end
  end

  always_comb begin
    glyph_nxt = hex_glyph(disp_buf[scan_idx]);
    if (disp_ovf)             glyph_nxt = SEG_DASH;
    else if (blank[scan_idx]) glyph_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out      <= '0;
      digit_select <= '0;
    end else begin
      seg_out      <= glyph_nxt;
      digit_select <= DIGITS'(1) << scan_idx;
    end
  end

endmodule
